obstacle_sched: RTL and testbench
=================================

# obstacle_sched

Sequencing controller for obstacle placement in the snake playfield. It owns the 15-entry obstacle table and decides when a new obstacle is due, based on apple pickups and snake length. For each placement it draws a random candidate cell, scans the snake body serially through a one-segment read port, and checks the candidate against existing obstacles. It then commits the cell or retries. It also answers the renderer's per-pixel "is obstacle" query.

## Interface
- MAX_LENGTH, 50: body array depth; also the cap on scan length.
- MAX_OBS, 15: obstacle table entries (4-bit count; MAX_OBS ≤ 15).
- MAX_TRIES, 8: candidate draws per placement before giving up.

Ports:
- clk, in, 1: system clock.
- s_reset, in, 1: reset, synchronous, active-high.
- obstacleFlag, in, 1: obstacle mode enable; 0 acts as a synchronous clear.
- goodColl, in, 1: one-cycle pulse when an apple is eaten.
- randX, randY, in, 4 each: free-running random source, sampled in DRAW.
- curr_length, in, 8: current snake length.
- body_idx, out, 6: body segment index being read.
- body_seg, in, 8: {x,y} of segment body_idx. Combinational, same cycle.
- x, y, in, 4 each: renderer query cell.
- obstacle, out, 1: combinational; 1 iff {x,y} matches a valid table entry.
- obstacleCount, out, 4: number of valid table entries.
- busy, out, 1: state ≠ IDLE.
- placed, out, 1: one-cycle pulse; an obstacle was committed.
- fail, out, 1: one-cycle pulse; MAX_TRIES draws were rejected.

## Operation
- Cell encoding is {x[3:0], y[3:0]}. Legal cells are x 1..14 and y 1..10.
- States: IDLE, DRAW, SCAN, DECIDE.
- Pickup divider: a 2-bit counter increments on every accepted goodColl.
  - A placement is due when goodColl arrives with the counter at 0, so on pickups 1, 5, 9, …
- Quota: a due placement proceeds only if obstacleCount < MAX_OBS and (curr_length < 3 or 2·(obstacleCount+1) < curr_length+2).
  - Arithmetic is 9-bit unsigned.
  - If the quota fails, the request is dropped with no pulse.
- IDLE: a due placement that passes quota moves to DRAW, with tries = 0.
- DRAW (1 cycle):
  - Latch cand = {randX, randY}.
  - Latch N = min(max(curr_length, 1), MAX_LENGTH).
  - Compute obs_bad: cand lies within Chebyshev distance ≤ 1 of any valid entry.
  - Compute range_bad: cand is outside the legal cells.
  - Clear body_bad. Go to SCAN with idx = 0.
- SCAN (N cycles): body_idx = idx.
  - Set body_bad if body_seg == cand.
  - When idx == 0, also set body_bad if cand is one of the head's four orthogonal neighbours, i.e. head ±0x10 or ±0x01 in 8-bit arithmetic.
  - After idx == N−1, go to DECIDE.
- DECIDE (1 cycle), with reject = range_bad | obs_bad | body_bad:
  - If !reject: write cand to entry obstacleCount, increment the count, pulse placed next cycle, go to IDLE.
  - If reject and tries < MAX_TRIES−1: increment tries, go to DRAW.
  - Otherwise: pulse fail next cycle, go to IDLE.
- body_idx = 0 outside SCAN.
- Pending request: a goodColl arriving while busy still advances the divider.
  - If it makes a placement due, set pend. Only one request is held; further due requests while pend = 1 are dropped.
  - In IDLE with pend = 1, clear pend and re-evaluate quota as if goodColl had just arrived.
- Clear: s_reset = 1 or obstacleFlag = 0 at a clock edge sets:
  - state IDLE, table invalid, obstacleCount 0, divider 0, pend 0, tries 0, placed 0, fail 0.
  - A clear mid-SCAN aborts the placement with no write.
- s_reset/clear takes priority over goodColl in the same cycle.

## Timing
- Reset values:
  - obstacleCount 0, busy 0, placed 0, fail 0, body_idx 0.
  - obstacle 0, because the table is all-invalid.
- Single-try latency: goodColl high before edge t gives DRAW in cycle t+1, SCAN in t+2..t+N+1, DECIDE in t+N+2.
  - placed is high and the new entry is visible to obstacle and obstacleCount in cycle t+N+3.
- Each retry adds N+2 cycles.
- curr_length changes during an attempt have no effect until the next DRAW.
- obstacle is purely combinational on x, y and registered table state. No added latency.
- placed and fail are never high together. Each is high for exactly one cycle.

## Test plan
- Reset then enable. curr_length=10; goodColl once; rand gives x=5, y=3, body at (8,8)…: placed 13 cycles after goodColl, obstacleCount=1; query (5,3) gives obstacle=1 and (5,4) gives 0.
- Divider/pend: 5 goodColl pulses 1 cycle apart, curr_length=20, legal rand: exactly 2 placements, the second started from pend immediately after the first returns to IDLE.
- Retry: first draw equals body[3], second draw equals head+0x01, third draw is legal and clear: placed after 3·(N+2)+1 cycles from goodColl, one entry written.
- Give up: rand held at (0,0), out of range: fail pulses after MAX_TRIES attempts, obstacleCount unchanged.
- Proximity/quota:
  - Existing entry (6,6), candidate (7,7): rejected.
  - curr_length=4, count=2: quota fails (6 < 6 false); no busy, no pulse.
- Clear mid-SCAN: deassert obstacleFlag during SCAN: next cycle busy=0, count=0, obstacle=0 everywhere, no placed pulse.

Source files
------------

// File: rtl/obstacle_sched.sv
// obstacle_sched: owns the 15-entry obstacle table for the snake playfield.
// Each apple pickup steps a divider. A placement is due on pickups 1, 5, 9, ...
// and runs only if the quota allows it. Each placement draws a random cell,
// scans the snake body one segment per cycle, checks how close the cell is to
// existing obstacles, and then commits the cell or draws again.
// The renderer's "is obstacle" lookup is answered combinationally.
module obstacle_sched #(
  parameter int MAX_LENGTH = 50,
  parameter int MAX_OBS    = 15,
  parameter int MAX_TRIES  = 8
) (
  input  logic       clk,
  input  logic       s_reset,
  input  logic       obstacleFlag,
  input  logic       goodColl,
  input  logic [3:0] randX,
  input  logic [3:0] randY,
  input  logic [7:0] curr_length,
  output logic [5:0] body_idx,
  input  logic [7:0] body_seg,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       obstacle,
  output logic [3:0] obstacleCount,
  output logic       busy,
  output logic       placed,
  output logic       fail
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRAW   = 2'd1,
    S_SCAN   = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  // True when two 4-bit coordinates differ by at most one. The compare is
  // widened to 5 bits so that 15+1 does not wrap around to 0.
  function automatic logic near1(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] ea;
    logic [4:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return ((ea + 5'd1) >= eb) && ((eb + 5'd1) >= ea);
  endfunction

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_div;
  logic            r_pend;
  logic [TW-1:0]   r_tries;
  logic [7:0]      r_cand;
  logic [5:0]      r_n;
  logic [5:0]      r_idx;
  logic            r_obs_bad;
  logic            r_range_bad;
  logic            r_body_bad;
  logic [7:0]      r_tab [MAX_OBS];
  logic [MAX_OBS-1:0] r_valid;
  logic [3:0]      r_count;
  logic            r_placed;
  logic            r_fail;

  logic            w_clr;
  logic            w_due;
  logic            w_quota;
  logic [8:0]      w_cnt_p1;
  logic [8:0]      w_lhs;
  logic [8:0]      w_rhs;
  logic [5:0]      w_len;
  logic            w_obs_bad;
  logic            w_range_bad;
  logic            w_body_hit;
  logic            w_reject;
  logic            w_hit;
  logic            w_start;
  logic            w_commit;
  logic            w_retry;
  logic            w_giveup;

  // Clearing obstacle mode behaves exactly like a reset.
  assign w_clr = s_reset | ~obstacleFlag;
  assign w_due = goodColl & (r_div == 2'd0);

  // Quota check and clamp of the scan length. Both use the live inputs.
  always_comb begin
    w_cnt_p1 = {5'd0, r_count} + 9'd1;
    w_lhs    = w_cnt_p1 + w_cnt_p1;
    w_rhs    = {1'b0, curr_length} + 9'd2;
    w_quota  = (r_count < 4'(MAX_OBS)) && ((curr_length < 8'd3) || (w_lhs < w_rhs));
    if (curr_length == 8'd0) begin
      w_len = 6'd1;
    end else if (curr_length > 8'(MAX_LENGTH)) begin
      w_len = 6'(MAX_LENGTH);
    end else begin
      w_len = curr_length[5:0];
    end
  end

  // Test the fresh candidate against the table and the legal playfield.
  always_comb begin
    w_obs_bad = 1'b0;
    for (int i = 0; i < MAX_OBS; i++) begin
      w_obs_bad = w_obs_bad | (r_valid[i] & near1(r_tab[i][7:4], randX)
                                          & near1(r_tab[i][3:0], randY));
    end
    w_range_bad = (randX < 4'd1) | (randX > 4'd14) | (randY < 4'd1) | (randY > 4'd10);
  end

  // Body hit for the segment now on the read port. The head also blocks its
  // four orthogonal neighbours.
  always_comb begin
    w_body_hit = (body_seg == r_cand);
    if (r_idx == 6'd0) begin
      w_body_hit = w_body_hit
                 | (r_cand == (body_seg + 8'h10)) | (r_cand == (body_seg - 8'h10))
                 | (r_cand == (body_seg + 8'h01)) | (r_cand == (body_seg - 8'h01));
    end else begin
      w_body_hit = w_body_hit;
    end
  end

  assign w_reject = r_range_bad | r_obs_bad | r_body_bad;

  // Renderer lookup: does the cell match any valid table entry?
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < MAX_OBS; i++) begin
      w_hit = w_hit | (r_valid[i] & (r_tab[i] == {x, y}));
    end
  end

  // Next-state logic and the one-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_retry      = 1'b0;
    w_giveup     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_due | r_pend) & w_quota) begin
          w_state_next = S_DRAW;
          w_start      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_DRAW: begin
        w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_idx == (r_n - 6'd1)) begin
          w_state_next = S_DECIDE;
        end else begin
          w_state_next = S_SCAN;
        end
      end
      S_DECIDE: begin
        if (!w_reject) begin
          w_state_next = S_IDLE;
          w_commit     = 1'b1;
        end else if (r_tries < TW'(MAX_TRIES - 1)) begin
          w_state_next = S_DRAW;
          w_retry      = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_giveup     = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pickup divider and the single pending-request slot. In IDLE a request is
  // served straight away, so the slot only stays full if a fresh due pickup
  // arrives in the same cycle as the held request.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_div  <= 2'd0;
      r_pend <= 1'b0;
    end else begin
      if (goodColl) begin
        r_div <= r_div + 2'd1;
      end
      if (r_state == S_IDLE) begin
        r_pend <= r_pend & w_due;
      end else if (w_due) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Candidate latch and the serial body scan.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cand      <= 8'd0;
      r_n         <= 6'd1;
      r_idx       <= 6'd0;
      r_obs_bad   <= 1'b0;
      r_range_bad <= 1'b0;
      r_body_bad  <= 1'b0;
      r_tries     <= '0;
    end else begin
      case (r_state)
        S_DRAW: begin
          r_cand      <= {randX, randY};
          r_n         <= w_len;
          r_obs_bad   <= w_obs_bad;
          r_range_bad <= w_range_bad;
          r_body_bad  <= 1'b0;
          r_idx       <= 6'd0;
        end
        S_SCAN: begin
          r_body_bad <= r_body_bad | w_body_hit;
          r_idx      <= r_idx + 6'd1;
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
      if (w_start) begin
        r_tries <= '0;
      end else if (w_retry) begin
        r_tries <= r_tries + TW'(1);
      end
    end
  end

  // Obstacle table: append the committed cell at the slot given by the count.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_valid <= '0;
      r_count <= 4'd0;
      for (int i = 0; i < MAX_OBS; i++) begin
        r_tab[i] <= 8'd0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < MAX_OBS; i++) begin
        if (4'(i) == r_count) begin
          r_tab[i]   <= r_cand;
          r_valid[i] <= 1'b1;
        end
      end
      r_count <= r_count + 4'd1;
    end
  end

  // Result pulses. Commit and give-up are mutually exclusive, so at most one
  // pulse fires.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_placed <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_placed <= w_commit;
      r_fail   <= w_giveup;
    end
  end

  assign body_idx      = (r_state == S_SCAN) ? r_idx : 6'd0;
  assign busy          = (r_state != S_IDLE);
  assign obstacle      = w_hit;
  assign obstacleCount = r_count;
  assign placed        = r_placed;
  assign fail          = r_fail;

endmodule

// File: tb/tb_obstacle_sched.sv
// Directed bench for obstacle_sched. Stimulus pushes the pulses it expects
// (kind, cycle, table count) into a scoreboard queue. A monitor pops one entry
// whenever placed or fail fires and compares the pulse against it.
module tb_obstacle_sched;

  logic       clk = 1'b0;
  logic       s_reset;
  logic       obstacleFlag;
  logic       goodColl;
  logic [3:0] randX;
  logic [3:0] randY;
  logic [7:0] curr_length;
  logic [5:0] body_idx;
  logic [7:0] body_seg;
  logic [3:0] x;
  logic [3:0] y;
  logic       obstacle;
  logic [3:0] obstacleCount;
  logic       busy;
  logic       placed;
  logic       fail;

  logic [7:0] body [0:63];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit         is_fail;
    int         exp_cyc;
    logic [3:0] exp_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  obstacle_sched dut (
    .clk(clk), .s_reset(s_reset), .obstacleFlag(obstacleFlag), .goodColl(goodColl),
    .randX(randX), .randY(randY), .curr_length(curr_length), .body_idx(body_idx),
    .body_seg(body_seg), .x(x), .y(y), .obstacle(obstacle),
    .obstacleCount(obstacleCount), .busy(busy), .placed(placed), .fail(fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign body_seg = body[body_idx];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (placed || fail) begin
      check("pulse_exclusive", 32'(placed & fail), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, placed, fail}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(fail), 32'(e.is_fail));
        check("pulse_cycle", cyc, e.exp_cyc);
        check("count_at_pulse", 32'(obstacleCount), 32'(e.exp_cnt));
      end
    end
  end

  // Draw the body as a horizontal line, head first, with x stepping down.
  task automatic set_body(input logic [3:0] hx, input logic [3:0] hy);
    logic [3:0] bx;
    for (int i = 0; i < 64; i++) begin
      bx = hx - 4'(i);
      body[i] = {bx, hy};
    end
  endtask

  // Raise goodColl for one cycle. Call at a negedge; c returns the cycle
  // index in which the pulse was high.
  task automatic pulse_gc(output int c);
    c = cyc;
    goodColl = 1'b1;
    @(negedge clk);
    goodColl = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) begin
      n_chk++;
      $display("FAIL wait_cyc: reached %0d, wanted %0d", cyc, target);
    end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check(name, sb.size(), 32'd0);
  endtask

  task automatic clear_flag();
    obstacleFlag = 1'b0;
    @(negedge clk);
    obstacleFlag = 1'b1;
  endtask

  task automatic query(input logic [3:0] qx, input logic [3:0] qy, input logic exp, input string name);
    x = qx;
    y = qy;
    #1;
    check(name, 32'(obstacle), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic any;
    s_reset = 1'b1; obstacleFlag = 1'b0; goodColl = 1'b0;
    randX = 4'd0; randY = 4'd0; curr_length = 8'd10; x = 4'd0; y = 4'd0;
    set_body(4'd8, 4'd8);
    repeat (3) @(negedge clk);
    check("rst_count", 32'(obstacleCount), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_placed", 32'(placed), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_body_idx", 32'(body_idx), 32'd0);
    query(4'd0, 4'd0, 1'b0, "rst_obstacle");
    s_reset = 1'b0; obstacleFlag = 1'b1;
    @(negedge clk);

    // Single try: N=10, so placed arrives 13 cycles after goodColl.
    randX = 4'd5; randY = 4'd3;
    pulse_gc(c);
    sb.push_back('{1'b0, c + 13, 4'd1});
    wait_cyc(c + 5);
    check("scan_body_idx", 32'(body_idx), 32'd3);
    check("scan_busy", 32'(busy), 32'd1);
    drain("t1_drain");
    query(4'd5, 4'd3, 1'b1, "t1_hit");
    query(4'd5, 4'd4, 1'b0, "t1_miss");
    check("t1_count", 32'(obstacleCount), 32'd1);

    // Divider and pending request: five pulses, N=20, two placements.
    clear_flag();
    check("clr_count", 32'(obstacleCount), 32'd0);
    query(4'd5, 4'd3, 1'b0, "clr_table");
    curr_length = 8'd20;
    set_body(4'd12, 4'd9);
    randX = 4'd3; randY = 4'd3;
    pulse_gc(c);
    sb.push_back('{1'b0, c + 23, 4'd1});
    sb.push_back('{1'b0, c + 46, 4'd2});
    @(negedge clk);
    randX = 4'd10; randY = 4'd5;
    for (int k = 0; k < 4; k++) begin
      int d;
      pulse_gc(d);
      @(negedge clk);
    end
    drain("t2_drain");
    check("t2_count", 32'(obstacleCount), 32'd2);
    query(4'd3, 4'd3, 1'b1, "t2_first");
    query(4'd10, 4'd5, 1'b1, "t2_second");

    // Retry: body hit, then head neighbour, then a clean cell.
    clear_flag();
    curr_length = 8'd10;
    set_body(4'd12, 4'd8);
    randX = 4'd9; randY = 4'd8;
    pulse_gc(c);
    sb.push_back('{1'b0, c + 37, 4'd1});
    wait_cyc(c + 2);
    randX = 4'd12; randY = 4'd9;
    wait_cyc(c + 14);
    randX = 4'd2; randY = 4'd10;
    drain("t3_drain");
    query(4'd2, 4'd10, 1'b1, "t3_hit");
    query(4'd9, 4'd8, 1'b0, "t3_body_rej");
    query(4'd12, 4'd9, 1'b0, "t3_head_rej");

    // Give up: (0,0) is out of range on all eight draws.
    clear_flag();
    randX = 4'd0; randY = 4'd0;
    pulse_gc(c);
    sb.push_back('{1'b1, c + 97, 4'd0});
    wait_cyc(c + 50);
    check("t4_busy", 32'(busy), 32'd1);
    drain("t4_drain");
    check("t4_count", 32'(obstacleCount), 32'd0);

    // Proximity: (7,7) sits next to (6,6), so the second draw is used.
    clear_flag();
    randX = 4'd6; randY = 4'd6;
    pulse_gc(c);
    sb.push_back('{1'b0, c + 13, 4'd1});
    drain("t5a_drain");
    for (int k = 0; k < 3; k++) begin
      int d;
      pulse_gc(d);
      @(negedge clk);
    end
    randX = 4'd7; randY = 4'd7;
    pulse_gc(c);
    sb.push_back('{1'b0, c + 25, 4'd2});
    wait_cyc(c + 2);
    randX = 4'd10; randY = 4'd2;
    drain("t5b_drain");
    query(4'd7, 4'd7, 1'b0, "t5_near_rej");
    query(4'd10, 4'd2, 1'b1, "t5_hit");

    // Quota: length 4 with two entries gives 6 < 6, so the request is dropped.
    curr_length = 8'd4;
    for (int k = 0; k < 4; k++) begin
      int d;
      pulse_gc(d);
      check("quota_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("quota_busy_late", 32'(busy), 32'd0);
    check("quota_count", 32'(obstacleCount), 32'd2);

    // Clear during SCAN aborts the placement without a write.
    curr_length = 8'd20;
    randX = 4'd13; randY = 4'd1;
    for (int k = 0; k < 3; k++) begin
      int d;
      pulse_gc(d);
      @(negedge clk);
    end
    pulse_gc(c);
    wait_cyc(c + 5);
    check("t6_busy_scan", 32'(busy), 32'd1);
    obstacleFlag = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_count", 32'(obstacleCount), 32'd0);
    check("t6_body_idx", 32'(body_idx), 32'd0);
    any = 1'b0;
    for (int i = 0; i < 256; i++) begin
      x = i[7:4];
      y = i[3:0];
      #1;
      any = any | obstacle;
    end
    check("t6_table_empty", 32'(any), 32'd0);
    @(negedge clk);
    obstacleFlag = 1'b1;
    repeat (40) @(negedge clk);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
